// File: rtl/mode_select_ctrl_pkg.sv
// Shared types and constants for the operation-select sequencer.
//   mode_t      : 2-bit operation select, MODE0..MODE3
//   NUM_MODES   : number of selectable operations
//   KEY_PRESSED : level of a pressed (active-low) push button
//   mode_step   : next mode one step forward or back, wrapping modulo NUM_MODES
package mode_select_pkg;

  localparam int unsigned SEL_W     = 2;
  localparam int unsigned NUM_MODES = 4;
  localparam logic        KEY_PRESSED = 1'b0;

  typedef enum logic [SEL_W-1:0] {
    MODE0 = 2'd0,
    MODE1 = 2'd1,
    MODE2 = 2'd2,
    MODE3 = 2'd3
  } mode_t;

  // Stepping back is done as adding NUM_MODES-1 so the result stays modulo NUM_MODES.
  function automatic mode_t mode_step(input mode_t m, input logic fwd);
    logic [31:0] sum;
    sum = 32'(m) + (fwd ? 32'd1 : 32'(NUM_MODES - 1));
    return mode_t'(SEL_W'(sum % 32'(NUM_MODES)));
  endfunction

endpackage

// File: rtl/mode_select_ctrl_if.sv
// Key inputs and mode/display outputs of the operation-select sequencer.
//   key0_n, key1_n : raw active-low push buttons (asynchronous)
//   select         : registered operation select to the multiplexer
//   mode_led       : mode indicator LEDs, mirrors select
//   mode_strobe    : one-cycle pulse after each processed press
//   disp_valid     : seven-segment path may show the multiplexer output
// master = key source / output consumer, slave = the sequencer.
interface mode_select_ctrl_if;
  import mode_select_pkg::*;

  logic             key0_n;
  logic             key1_n;
  logic [SEL_W-1:0] select;
  logic [SEL_W-1:0] mode_led;
  logic             mode_strobe;
  logic             disp_valid;

  modport master (
    output key0_n, key1_n,
    input  select, mode_led, mode_strobe, disp_valid
  );

  modport slave (
    input  key0_n, key1_n,
    output select, mode_led, mode_strobe, disp_valid
  );
endinterface

// File: rtl/mode_select_ctrl_key_debounce.sv
// Push-button conditioner: 2-flop synchronizer, hold-time debounce and a
// registered one-cycle press pulse.
//   clk, rst : clock, synchronous active-high reset
//   key_n    : raw active-low button, asynchronous
//   press    : one-cycle pulse when the debounced state becomes pressed
module key_debounce
  import mode_select_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [1:0]       fill_q;
  logic             db_q;
  logic             db_prev_q;
  logic             armed_q;
  logic [CNT_W-1:0] cnt_q;

  logic key_s;
  logic differ;
  logic qualify;

  assign key_s   = sync_q[1];
  assign differ  = (key_s != db_q);
  assign qualify = differ && (cnt_q == CNT_LAST);

  // fill_q marks when sync_q[1] holds a real key sample again after reset.
  // armed_q stays low until a genuine released sample is seen, so a key held
  // through reset is re-qualified silently and only a fresh press fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= {2{~KEY_PRESSED}};
      fill_q    <= 2'b00;
      db_q      <= ~KEY_PRESSED;
      db_prev_q <= ~KEY_PRESSED;
      armed_q   <= 1'b0;
      cnt_q     <= '0;
      press     <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], key_n};
      fill_q    <= {fill_q[0], 1'b1};
      db_prev_q <= db_q;
      if (!differ || qualify) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (qualify) begin
        db_q <= key_s;
      end
      if (fill_q[1] && (key_s != KEY_PRESSED)) begin
        armed_q <= 1'b1;
      end
      press <= armed_q && (db_q == KEY_PRESSED) && (db_prev_q != KEY_PRESSED);
    end
  end

endmodule

// File: rtl/mode_select_ctrl.sv
// Operation-select sequencer: steps a registered 2-bit select from debounced
// key presses and blanks the display for a settle window after each change.
//   clk, rst : clock, synchronous active-high reset
//   bus      : key inputs and select/mode_led/mode_strobe/disp_valid outputs
module mode_select_ctrl
  import mode_select_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned BLANK_CYCLES    = 16,
  parameter int unsigned CNT_W           = 20
) (
  input  logic                clk,
  input  logic                rst,
  mode_select_ctrl_if.slave   bus
);

  localparam int unsigned BLK_W      = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam int unsigned BLANK_LOAD = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;

  logic press0;
  logic press1;

  mode_t            state_q,     state_d;
  logic             strobe_q,    strobe_d;
  logic             disp_valid_q, disp_valid_d;
  logic [BLK_W-1:0] blank_cnt_q, blank_cnt_d;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_key0 (
    .clk   (clk),
    .rst   (rst),
    .key_n (bus.key0_n),
    .press (press0)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_key1 (
    .clk   (clk),
    .rst   (rst),
    .key_n (bus.key1_n),
    .press (press1)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= MODE0;
      strobe_q     <= 1'b0;
      disp_valid_q <= 1'b1;
      blank_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      strobe_q     <= strobe_d;
      disp_valid_q <= disp_valid_d;
      blank_cnt_q  <= blank_cnt_d;
    end
  end

  // Mode transitions, strobe and blank window; a press always wins over the
  // running countdown so a late press extends the window.
  always_comb begin
    state_d      = state_q;
    strobe_d     = 1'b0;
    disp_valid_d = disp_valid_q;
    blank_cnt_d  = blank_cnt_q;

    if (!disp_valid_q) begin
      if (blank_cnt_q == '0) begin
        disp_valid_d = 1'b1;
      end else begin
        blank_cnt_d = blank_cnt_q - BLK_W'(1);
      end
    end

    unique case ({press0, press1})
      2'b10:   state_d = mode_step(state_q, 1'b1);
      2'b01:   state_d = mode_step(state_q, 1'b0);
      2'b11:   state_d = MODE0;
      default: state_d = state_q;
    endcase

    if (press0 || press1) begin
      strobe_d = 1'b1;
      if (BLANK_CYCLES > 0) begin
        disp_valid_d = 1'b0;
        blank_cnt_d  = BLK_W'(BLANK_LOAD);
      end
    end
  end

  assign bus.select      = state_q;
  assign bus.mode_led    = state_q;
  assign bus.mode_strobe = strobe_q;
  assign bus.disp_valid  = disp_valid_q;

endmodule
